// File: rtl/mult_pipe_cfg.sv
// Pipelined shift-add multiplier with per-operand signed/unsigned modes, valid/ready backpressure
// and a control sideband that rides alongside each word so it stays aligned with its product.
module mult_pipe_cfg #(
  parameter int unsigned WIDTH_A               = 8,
  parameter int unsigned WIDTH_B               = 8,
  parameter int unsigned STAGES                = 4,
  parameter int unsigned CONTROL_SIGNALS_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH_A-1:0]                 a,
  input  logic [WIDTH_B-1:0]                 b,
  input  logic                               a_signed,
  input  logic                               b_signed,
  input  logic [CONTROL_SIGNALS_WIDTH-1:0]   control_signals_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH_A+WIDTH_B-1:0]         result,
  output logic [CONTROL_SIGNALS_WIDTH-1:0]   control_signals_out
);

  localparam int unsigned PW    = WIDTH_A + WIDTH_B;
  localparam int unsigned Chunk = (STAGES == 0) ? WIDTH_B : (WIDTH_B + STAGES - 1) / STAGES;

  if (STAGES < 1 || STAGES > WIDTH_B) begin : g_bad_stages
    $error("mult_pipe_cfg: STAGES must lie in 1..WIDTH_B");
  end

  // Partial product of one chunk of b starting at bit lo. The MSB of b is subtracted when b is
  // signed, which together with sign-extending a gives the exact product modulo 2^PW.
  function automatic logic [PW-1:0] chunk_pp(input logic [WIDTH_A-1:0] op_a,
                                             input logic               a_sgn,
                                             input logic [WIDTH_B-1:0] op_b,
                                             input logic               b_sgn,
                                             input int unsigned        lo);
    logic [PW-1:0]      a_ext;
    logic [PW-1:0]      acc;
    logic [WIDTH_B-1:0] b_sh;
    int unsigned        pos;
    a_ext = {{WIDTH_B{a_sgn & op_a[WIDTH_A-1]}}, op_a};
    b_sh  = op_b >> lo;
    acc   = '0;
    for (int unsigned i = 0; i < Chunk; i++) begin
      pos = lo + i;
      if (pos < WIDTH_B && b_sh[i]) begin
        if (b_sgn && pos == WIDTH_B - 1) begin
          acc = acc - (a_ext << pos);
        end else begin
          acc = acc + (a_ext << pos);
        end
      end
    end
    return acc;
  endfunction

  logic                             adv;

  logic [STAGES-1:0]                vld_q, vld_d;
  logic [PW-1:0]                    psum_q [STAGES];
  logic [PW-1:0]                    psum_d [STAGES];
  logic [WIDTH_A-1:0]               a_q    [STAGES];
  logic [WIDTH_A-1:0]               a_d    [STAGES];
  logic [WIDTH_B-1:0]               b_q    [STAGES];
  logic [WIDTH_B-1:0]               b_d    [STAGES];
  logic [STAGES-1:0]                a_sgn_q, a_sgn_d;
  logic [STAGES-1:0]                b_sgn_q, b_sgn_d;
  logic [CONTROL_SIGNALS_WIDTH-1:0] ctrl_q [STAGES];
  logic [CONTROL_SIGNALS_WIDTH-1:0] ctrl_d [STAGES];

  // One global enable: the whole pipe moves together, bubbles included.
  assign adv      = !vld_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign vld_d[0]   = in_valid;
      assign a_d[0]     = a;
      assign b_d[0]     = b;
      assign a_sgn_d[0] = a_signed;
      assign b_sgn_d[0] = b_signed;
      assign ctrl_d[0]  = control_signals_in;
      assign psum_d[0]  = chunk_pp(a, a_signed, b, b_signed, 0);
    end else begin : g_next
      assign vld_d[k]   = vld_q[k-1];
      assign a_d[k]     = a_q[k-1];
      assign b_d[k]     = b_q[k-1];
      assign a_sgn_d[k] = a_sgn_q[k-1];
      assign b_sgn_d[k] = b_sgn_q[k-1];
      assign ctrl_d[k]  = ctrl_q[k-1];
      assign psum_d[k]  = psum_q[k-1]
                        + chunk_pp(a_q[k-1], a_sgn_q[k-1], b_q[k-1], b_sgn_q[k-1], k * Chunk);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q   <= '0;
      a_sgn_q <= '0;
      b_sgn_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        psum_q[k] <= '0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        ctrl_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q   <= vld_d;
      a_sgn_q <= a_sgn_d;
      b_sgn_q <= b_sgn_d;
      for (int k = 0; k < STAGES; k++) begin
        psum_q[k] <= psum_d[k];
        a_q[k]    <= a_d[k];
        b_q[k]    <= b_d[k];
        ctrl_q[k] <= ctrl_d[k];
      end
    end
  end

  assign out_valid           = vld_q[STAGES-1];
  assign result              = psum_q[STAGES-1];
  assign control_signals_out = ctrl_q[STAGES-1];

endmodule

// File: doc/mult_pipe_cfg.md
# mult_pipe_cfg

Parametrised pipelined multiplier, the successor to the fixed signed multiplier used in the FIR datapath. It adds the following over that block:
- independent operand widths;
- configurable pipeline depth;
- per-operation signed/unsigned mode for each operand;
- a valid/ready handshake with backpressure.

A control sideband word travels through the pipeline alongside its operands, so FIR tap/accumulate control stays aligned with the product.

## Interface
Parameters:
- WIDTH_A, 8: bit width of operand a.
- WIDTH_B, 8: bit width of operand b.
- STAGES, 4: pipeline depth. Legal range is 1..WIDTH_B; elaboration error outside that range.
- CONTROL_SIGNALS_WIDTH, 8: sideband width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand word presented.
- in_ready  out  1  pipeline accepts the word this cycle.
- a  in  WIDTH_A  multiplicand.
- b  in  WIDTH_B  multiplier.
- a_signed  in  1  1 = a is two's complement, 0 = unsigned.
- b_signed  in  1  1 = b is two's complement, 0 = unsigned.
- control_signals_in  in  CONTROL_SIGNALS_WIDTH  sideband, captured with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH_A+WIDTH_B  product.
- control_signals_out  out  CONTROL_SIGNALS_WIDTH  sideband of the word on result.

## Operation
- result is the exact mathematical product of a and b, each interpreted per its own mode flag, taken modulo 2^(WIDTH_A+WIDTH_B). This width holds every mixed-mode product exactly.
- Partial-product accumulation is split across STAGES registered stages:
  - Stage k consumes bit chunk k of b, chunk size ceil(WIDTH_B/STAGES); the last chunk may be shorter.
  - When b_signed=1, the MSB of b carries negative weight.
  - When a_signed=1, a is sign-extended into each partial product.
  - A single-cycle full-width multiply is not permitted.
- Each stage holds: valid bit, partial sum, remaining a/b bits, both mode flags, sideband word.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational).
- On adv, every stage shifts forward one place. Stage 0 loads the input word with valid = in_valid. A word is transferred into the pipeline only when in_valid && in_ready.
- When adv=0, every stage register holds its value, including bubbles. Bubbles are not compressed.
- The output stage drives result, control_signals_out and out_valid directly from registers.
- While out_valid=1 and out_ready=0, result and control_signals_out are stable.

## Timing
- Reset (rst=0, asynchronous): all stage valid bits, partial sums and sidebands clear to 0. out_valid=0, result=0, control_signals_out=0.
- in_ready is 1 from the first cycle after reset release, because out_valid=0.
- Latency: with out_ready held 1, a word accepted at edge n appears with out_valid=1 after edge n+STAGES.
- Throughput: one word per cycle with no stalls.
- STAGES=1: a registered multiplier with latency 1.
- Simultaneous events:
  - Output handshake completing and a new input accepted in the same cycle: both happen; the pipeline shifts once.
  - Output not accepted (out_valid=1, out_ready=0): in_ready=0 that cycle. An input with in_valid=1 is not taken and the source must hold it.
  - in_valid=0 with adv=1: a bubble (valid=0) enters stage 0.
- Reset asserted mid-operation: all in-flight words are discarded immediately. No result from before reset ever appears after reset.
- Sideband stays aligned: control_signals_out always equals the control_signals_in captured with the operands now on result.

## Test plan
Default parameters (8x8, STAGES=4) unless stated; operands given as hex, flags as (a_signed, b_signed).
- Reset: hold rst=0 with random inputs. Required: out_valid=0, result=16'h0000, control_signals_out=0, and in_ready=1 after release.
- Modes and latency, out_ready=1, one word per cycle with control_signals_in = 1,2,3:
  - a=D9, b=D5, (1,1) -> 16'h068D with ctrl 1.
  - a=D9, b=D5, (0,0) -> 16'hB48D with ctrl 2.
  - a=D9, b=D5, (1,0) -> 16'hDF8D with ctrl 3.
  - First out_valid appears exactly 4 cycles after the first accept, then the three results on consecutive cycles.
- Extremes:
  - 80x80, (1,1) -> 16'h4000.
  - FFxFF, (0,0) -> 16'hFE01.
  - 80xFF, (1,0) -> 16'h8080.
  - 00xFF, (1,1) -> 16'h0000.
- Backpressure: stream 10 words, e.g. i=1..10 with a = 3i+217, b = 2i+211 (8-bit wrap), ctrl=i, mixed modes. Drop out_ready for 5 cycles mid-stream. Required:
  - result is held stable during the stall;
  - in_ready=0 throughout the stall;
  - all 10 results arrive in order, none lost or duplicated, each matching a reference model.
- Reset mid-stream: assert rst for one cycle while 3 words are in flight. Required: out_valid drops immediately; none of the 3 words emerges afterwards; a new word then produces a correct result after 4 cycles.
- Parameter sweep: STAGES=1 and STAGES=8 with WIDTH_A=12, WIDTH_B=8, random operands and modes. Required: latency equals STAGES and results match the reference model.
